// File: rtl/mem_test_pkg.sv
// mem_test_pkg: shared definitions for the script-driven memory test sequencer.
//   - opcode encodings of the step record
//   - step-record field offsets as functions of AW, DW and RW
//   - sequencer state encoding
//   - error counter width
// Step record layout (MSB..LSB): {op[2:0], byte, reg[RW-1:0], adr[AW-1:0], imm[DW-1:0]}
package mem_test_pkg;

  localparam logic [2:0] OP_HALT = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WRI  = 3'd2;
  localparam logic [2:0] OP_WRR  = 3'd3;
  localparam logic [2:0] OP_CMP  = 3'd4;

  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int step_w(input int aw, input int dw, input int rw);
    return 3 + 1 + rw + aw + dw;
  endfunction

  function automatic int fld_adr_lo(input int dw);
    return dw;
  endfunction

  function automatic int fld_reg_lo(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int fld_byte_pos(input int aw, input int dw, input int rw);
    return aw + dw + rw;
  endfunction

  function automatic int fld_op_lo(input int aw, input int dw, input int rw);
    return aw + dw + rw + 1;
  endfunction

endpackage

// File: rtl/mem_test_seq_wdog.sv
// mem_test_wdog: ack watchdog for the ISSUE state.
// Down-counter loaded with TIMEOUT-1 whenever the bus is not waiting; expire
// pulses on the TIMEOUT-th consecutive waiting cycle without ack.
// Ports:
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   run            : sequencer is in ISSUE waiting for ack
//   ack_i          : slave acknowledge
//   expire         : one-cycle abandon request
module mem_test_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run,
  input  logic ack_i,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q;

  assign expire = run && !ack_i && (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= CW'(TIMEOUT - 1);
    end else if (!run || ack_i || expire) begin
      cnt_q <= CW'(TIMEOUT - 1);
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/mem_test_seq.sv
// mem_test_seq: Wishbone master replaying a step table from an external
// combinational ROM (reads, writes, read-compares) with scratch registers,
// saturating error count and pass/fail status.
// Optional feature: define MEM_TEST_TIMEOUT_EN to add an ack watchdog that
// abandons a step after TIMEOUT cycles and counts it as an error.
// Ports:
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   start_i               : run request (sampled only in IDLE)
//   step_idx_o / step_i   : ROM index out, step record in (same cycle)
//   adr_o, dat_o, we_o, byte_o, stb_o, cyc_o : Wishbone master
//   dat_i, ack_i          : Wishbone slave response
//   busy_o, done_o, fail_o, err_cnt_o, fail_step_o, last_dat_o : status
//
// state | meaning
// IDLE  | wait for start_i, clear status
// FETCH | sample step record, launch bus cycle or finish on HALT
// ISSUE | bus cycle active, wait for ack (or watchdog)
// DONE  | script finished, hold until reset
module mem_test_seq
  import mem_test_pkg::*;
#(
  parameter int AW      = 20,
  parameter int DW      = 16,
  parameter int STEPS   = 16,
  parameter int NREG    = 2,
  parameter int TIMEOUT = 255,
  localparam int SW     = $clog2(STEPS),
  localparam int RW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  output logic [SW-1:0]                 step_idx_o,
  input  logic [step_w(AW,DW,RW)-1:0]   step_i,
  output logic [AW-1:0]                 adr_o,
  output logic [DW-1:0]                 dat_o,
  output logic                          we_o,
  output logic                          byte_o,
  output logic                          stb_o,
  output logic                          cyc_o,
  input  logic [DW-1:0]                 dat_i,
  input  logic                          ack_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          fail_o,
  output logic [ERR_W-1:0]              err_cnt_o,
  output logic [SW-1:0]                 fail_step_o,
  output logic [DW-1:0]                 last_dat_o
);

  localparam int ADR_LO  = fld_adr_lo(DW);
  localparam int REG_LO  = fld_reg_lo(AW, DW);
  localparam int BYTE_AT = fld_byte_pos(AW, DW, RW);
  localparam int OP_LO   = fld_op_lo(AW, DW, RW);

  state_t state_q, state_d;

  logic [2:0]    f_op;
  logic          f_byte;
  logic [RW-1:0] f_reg;
  logic [AW-1:0] f_adr;
  logic [DW-1:0] f_imm;
  logic          f_halt;
  logic [DW-1:0] wr_dat;

  logic [2:0]    op_q;
  logic [RW-1:0] reg_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] regs_q [NREG];
  logic          expire;
  logic          bus_end;
  logic          err_hit;

  assign f_op   = step_i[OP_LO +: 3];
  assign f_byte = step_i[BYTE_AT];
  assign f_reg  = step_i[REG_LO +: RW];
  assign f_adr  = step_i[ADR_LO +: AW];
  assign f_imm  = step_i[0 +: DW];
  // Unused opcodes 5..7 end the script like HALT.
  assign f_halt = (f_op == OP_HALT) || (f_op > OP_CMP);

`ifdef MEM_TEST_TIMEOUT_EN
  mem_test_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .run     (state_q == ST_ISSUE),
    .ack_i   (ack_i),
    .expire  (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign bus_end = (state_q == ST_ISSUE) && (ack_i || expire);
  // A timed-out step counts as an error just like a compare mismatch.
  assign err_hit = (state_q == ST_ISSUE) &&
                   ((ack_i && (op_q == OP_CMP) && (dat_i != imm_q)) || (!ack_i && expire));

  always_comb begin
    wr_dat = '0;
    if (f_op == OP_WRI) begin
      wr_dat = f_imm;
    end else if (f_op == OP_WRR && int'(f_reg) < NREG) begin
      wr_dat = regs_q[f_reg];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_FETCH;
      ST_FETCH: state_d = f_halt ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (bus_end) state_d = (step_idx_o == SW'(STEPS - 1)) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      step_idx_o  <= '0;
      adr_o       <= '0;
      dat_o       <= '0;
      we_o        <= 1'b0;
      byte_o      <= 1'b0;
      stb_o       <= 1'b0;
      cyc_o       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
      err_cnt_o   <= '0;
      fail_step_o <= '0;
      last_dat_o  <= '0;
      op_q        <= OP_HALT;
      reg_q       <= '0;
      imm_q       <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      busy_o <= (state_d == ST_FETCH) || (state_d == ST_ISSUE);
      done_o <= (state_d == ST_DONE);

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            step_idx_o  <= '0;
            fail_o      <= 1'b0;
            err_cnt_o   <= '0;
            fail_step_o <= '0;
          end
        end
        ST_FETCH: begin
          if (!f_halt) begin
            adr_o  <= f_adr;
            dat_o  <= wr_dat;
            we_o   <= (f_op == OP_WRI) || (f_op == OP_WRR);
            byte_o <= f_byte;
            stb_o  <= 1'b1;
            cyc_o  <= 1'b1;
            op_q   <= f_op;
            reg_q  <= f_reg;
            imm_q  <= f_imm;
          end
        end
        ST_ISSUE: begin
          if (bus_end) begin
            stb_o <= 1'b0;
            cyc_o <= 1'b0;
            if (ack_i && (op_q == OP_RD || op_q == OP_CMP)) last_dat_o <= dat_i;
            if (ack_i && op_q == OP_RD && int'(reg_q) < NREG) regs_q[reg_q] <= dat_i;
            if (step_idx_o != SW'(STEPS - 1)) step_idx_o <= step_idx_o + 1'b1;
          end
          if (err_hit) begin
            if (err_cnt_o != {ERR_W{1'b1}}) err_cnt_o <= err_cnt_o + 1'b1;
            fail_o <= 1'b1;
            if (!fail_o) fail_step_o <= step_idx_o;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_test_seq.sv
module tb_mem_test_seq;
  import mem_test_pkg::*;

  localparam int AW = 20, DW = 16, STEPS = 512, NREG = 2, TIMEOUT = 8;
  localparam int SW  = $clog2(STEPS);
  localparam int RW  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int STW = 3 + 1 + RW + AW + DW;

  typedef struct packed {
    logic [2:0]    op;
    logic          b;
    logic [RW-1:0] r;
    logic [AW-1:0] adr;
    logic [DW-1:0] imm;
  } step_t;

  typedef struct packed {
    logic          we;
    logic          b;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } txn_t;

  logic clk = 0, rst_n = 0, start = 0;
  logic [SW-1:0] step_idx_o;
  logic [STW-1:0] step_i;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o, dat_i, last_dat_o;
  logic we_o, byte_o, stb_o, cyc_o, ack_i, busy_o, done_o, fail_o;
  logic [7:0] err_cnt_o;
  logic [SW-1:0] fail_step_o;

  step_t scr [STEPS];
  logic [DW-1:0] rdmem [256];
  logic ack_auto = 1, ack_force = 0;
  int no_ack_idx = -1;
  txn_t wlog [$];
  txn_t exp_q [$];

  int n_tests = 0, n_fail = 0;
  int e_T, e_hang, e_err, e_fail, e_fstep, e_idx;
  logic [DW-1:0] e_last;
  bit mon_en = 0;
  int mon_k = 0;
  logic stb_d = 0;

  always #5 clk = ~clk;

  assign step_i = scr[step_idx_o];
  assign dat_i  = rdmem[adr_o[7:0]];
  assign ack_i  = ack_force | (stb_o & ack_auto & (int'(step_idx_o) != no_ack_idx));

  mem_test_seq #(.AW(AW), .DW(DW), .STEPS(STEPS), .NREG(NREG), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .step_idx_o(step_idx_o), .step_i(step_i),
    .adr_o(adr_o), .dat_o(dat_o), .we_o(we_o), .byte_o(byte_o), .stb_o(stb_o), .cyc_o(cyc_o),
    .dat_i(dat_i), .ack_i(ack_i), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .err_cnt_o(err_cnt_o), .fail_step_o(fail_step_o), .last_dat_o(last_dat_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Slave side write log.
  always @(posedge clk)
    if (rst_n && stb_o && ack_i && we_o) wlog.push_back({we_o, byte_o, adr_o, dat_o});

  // Per-cycle compare against the step-level model.
  always @(negedge clk) begin
    txn_t t;
    if (mon_en) begin
      chk("busy", 32'(busy_o), 32'(mon_k < e_T));
      chk("done", 32'(done_o), 32'(mon_k >= e_T));
      chk("cyc_eq_stb", 32'(cyc_o), 32'(stb_o));
      if (stb_o && !stb_d) begin
        chk("bus_cycle_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          t = exp_q.pop_front();
          chk("we", 32'(we_o), 32'(t.we));
          chk("adr", 32'(adr_o), 32'(t.adr));
          chk("byte", 32'(byte_o), 32'(t.b));
          if (t.we) chk("wdat", 32'(dat_o), 32'(t.dat));
        end
      end
      mon_k++;
    end
    stb_d = stb_o;
  end

  // Step-level interpreter of the script: bus cycles, timing and final status.
  task automatic model();
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] d;
    txn_t t;
    for (int i = 0; i < NREG; i++) regs[i] = '0;
    exp_q.delete();
    e_T = 0; e_hang = 0; e_err = 0; e_fail = 0; e_fstep = 0; e_last = '0; e_idx = STEPS - 1;
    for (int i = 0; i < STEPS; i++) begin
      if (scr[i].op == 3'd0 || scr[i].op > 3'd4) begin
        e_T += 1; e_idx = i; break;
      end
      t.we  = (scr[i].op == 3'd2) || (scr[i].op == 3'd3);
      t.b   = scr[i].b;
      t.adr = scr[i].adr;
      t.dat = (scr[i].op == 3'd2) ? scr[i].imm : (scr[i].op == 3'd3) ? regs[scr[i].r] : '0;
      exp_q.push_back(t);
      if (i == no_ack_idx) begin
`ifdef MEM_TEST_TIMEOUT_EN
        e_T += 1 + TIMEOUT;
        if (e_err < 255) e_err++;
        if (!e_fail) begin e_fail = 1; e_fstep = i; end
        continue;
`else
        e_hang = 1; e_T = 1 << 30; break;
`endif
      end
      e_T += 2;
      d = rdmem[scr[i].adr[7:0]];
      if (scr[i].op == 3'd1) begin regs[scr[i].r] = d; e_last = d; end
      if (scr[i].op == 3'd4) begin
        e_last = d;
        if (d != scr[i].imm) begin
          if (e_err < 255) e_err++;
          if (!e_fail) begin e_fail = 1; e_fstep = i; end
        end
      end
    end
  endtask

  task automatic set_step(input int i, input int op, input int b, input int r, input int adr, input int imm);
    scr[i].op = 3'(op); scr[i].b = 1'(b); scr[i].r = RW'(r);
    scr[i].adr = AW'(adr); scr[i].imm = DW'(imm);
  endtask

  task automatic clear_script();
    for (int i = 0; i < STEPS; i++) scr[i] = '0;
    no_ack_idx = -1; ack_auto = 1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0; start = 0; ack_force = 0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    wlog.delete();
  endtask

  task automatic run_script(input string tag, input int budget);
    int waited = 0;
    model();
    @(negedge clk); start = 1;
    @(posedge clk); #1 mon_k = 0; mon_en = 1;
    while (!done_o && waited < budget) begin @(negedge clk); waited++; end
    if (e_hang) begin
      chk({tag, "_busy_held"}, 32'(busy_o), 32'd1);
      chk({tag, "_no_done"}, 32'(done_o), 32'd0);
    end else begin
      chk({tag, "_done_in_budget"}, 32'(done_o), 32'd1);
      @(negedge clk); @(negedge clk);
    end
    mon_en = 0;
    chk({tag, "_bus_cycles_left"}, 32'(exp_q.size()), 32'd0);
    if (!e_hang) begin
      chk({tag, "_err_cnt"}, 32'(err_cnt_o), 32'(e_err));
      chk({tag, "_fail"}, 32'(fail_o), 32'(e_fail));
      if (e_fail) chk({tag, "_fail_step"}, 32'(fail_step_o), 32'(e_fstep));
      chk({tag, "_last_dat"}, 32'(last_dat_o), 32'(e_last));
      chk({tag, "_step_idx"}, 32'(step_idx_o), 32'(e_idx));
    end
  endtask

  initial begin
    int w;
    for (int i = 0; i < 256; i++) rdmem[i] = '0;
    clear_script();
    do_reset();
    @(negedge clk);
    chk("rst_stb", 32'(stb_o), 0); chk("rst_cyc", 32'(cyc_o), 0);
    chk("rst_we", 32'(we_o), 0);   chk("rst_adr", 32'(adr_o), 0);
    chk("rst_busy", 32'(busy_o), 0); chk("rst_done", 32'(done_o), 0);
    chk("rst_fail", 32'(fail_o), 0); chk("rst_err", 32'(err_cnt_o), 0);
    chk("rst_idx", 32'(step_idx_o), 0); chk("rst_last", 32'(last_dat_o), 0);

    // RD reg0 then WRR reg0 (byte write)
    rdmem[8'h02] = 16'h0607;
    set_step(0, 1, 0, 0, 'hC0002, 0);
    set_step(1, 3, 1, 0, 'h2, 0);
    run_script("rd_wrr", 50);
    chk("rd_wrr_nwrites", 32'(wlog.size()), 1);
    if (wlog.size() > 0) begin
      chk("rd_wrr_wdat_lit", 32'(wlog[0].dat), 32'h0607);
      chk("rd_wrr_wadr_lit", 32'(wlog[0].adr), 32'h2);
      chk("rd_wrr_byte_lit", 32'(wlog[0].b), 1);
    end
    chk("rd_wrr_fail_lit", 32'(fail_o), 0);

    // CMP match and mismatch at step 3
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(); clear_script();
      rdmem[8'h10] = (pass == 0) ? 16'hFF83 : 16'h0083;
      for (int i = 0; i < 3; i++) set_step(i, 2, 0, 0, 'h40 + i, 'h1111 * i);
      set_step(3, 4, 1, 0, 'h10, 'hFF83);
      run_script(pass == 0 ? "cmp_ok" : "cmp_bad", 50);
      chk("cmp_err_lit", 32'(err_cnt_o), 32'(pass));
      if (pass == 1) chk("cmp_fstep_lit", 32'(fail_step_o), 3);
    end

    // mismatches at steps 2, 4, 5
    do_reset(); clear_script();
    rdmem[8'h10] = 16'hFF83;
    for (int i = 0; i < 6; i++)
      set_step(i, 4, 0, 0, 'h10, (i == 2 || i == 4 || i == 5) ? 'h1234 : 'hFF83);
    run_script("three_bad", 60);
    chk("three_err_lit", 32'(err_cnt_o), 3);
    chk("three_fstep_lit", 32'(fail_step_o), 2);

    // saturation: 300 mismatches, ended by unused opcode 7
    do_reset(); clear_script();
    for (int i = 0; i < 300; i++) set_step(i, 4, 0, 0, 'h10, 'h0);
    set_step(300, 7, 0, 0, 0, 0);
    run_script("sat", 700);
    chk("sat_err_lit", 32'(err_cnt_o), 255);
    chk("sat_idx_lit", 32'(step_idx_o), 300);

    // full table of writes, no HALT
    do_reset(); clear_script();
    for (int i = 0; i < STEPS; i++) set_step(i, 2, i & 1, 0, i, i * 3);
    run_script("full", 1200);
    chk("full_nwrites_lit", 32'(wlog.size()), STEPS);
    chk("full_idx_lit", 32'(step_idx_o), STEPS - 1);

    // immediate HALT
    do_reset(); clear_script();
    run_script("halt0", 10);
    chk("halt0_nwrites", 32'(wlog.size()), 0);
    chk("halt0_done_lit", 32'(done_o), 1);

    // reset while stb high, then late ack
    do_reset(); clear_script();
    rdmem[8'h02] = 16'h0607;
    set_step(0, 1, 0, 0, 'h2, 0);
    ack_auto = 0;
    @(negedge clk); start = 1;
    for (w = 0; w < 10 && !stb_o; w++) @(negedge clk);
    chk("rstmid_stb_seen", 32'(stb_o), 1);
    rst_n = 0;
    @(negedge clk);
    chk("rstmid_stb_low", 32'(stb_o), 0);
    chk("rstmid_cyc_low", 32'(cyc_o), 0);
    rst_n = 1; start = 0; ack_force = 1;
    @(negedge clk);
    ack_force = 0;
    chk("rstmid_busy", 32'(busy_o), 0);
    chk("rstmid_done", 32'(done_o), 0);
    chk("rstmid_last", 32'(last_dat_o), 0);
    chk("rstmid_err", 32'(err_cnt_o), 0);
    chk("rstmid_stb_after", 32'(stb_o), 0);
    ack_auto = 1;

    // slave never acks step 1
    do_reset(); clear_script();
    rdmem[8'h20] = 16'hBEEF;
    set_step(0, 2, 0, 0, 'h30, 'h00AA);
    set_step(1, 1, 0, 1, 'h20, 0);
    set_step(2, 2, 0, 0, 'h31, 'h00BB);
    no_ack_idx = 1;
    run_script("noack", 60);
`ifdef MEM_TEST_TIMEOUT_EN
    chk("noack_err_lit", 32'(err_cnt_o), 1);
    chk("noack_fstep_lit", 32'(fail_step_o), 1);
    chk("noack_nwrites_lit", 32'(wlog.size()), 2);
`else
    chk("noack_stb_held", 32'(stb_o), 1);
`endif
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
